// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_seq_ctrl
// Purpose  : Clear / skewed-compute / row-readout sequencer for a DIM x DIM
//            array of tpumac cells.
// Revision : 1.0  initial release
// ============================================================================
module systolic_seq_ctrl #(
    parameter int DIM = 8,
    parameter int AW  = 3,
    parameter int CW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mac_en,
    output logic              mac_wren,
    output logic [DIM-1:0]    feed_valid,
    output logic [DIM*AW-1:0] feed_addr,
    output logic [CW-1:0]     step,
    output logic              rd_valid,
    output logic [AW-1:0]     rd_row
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_COMPUTE = 3'd2,
        S_READ    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [CW-1:0] c_LAST_STEP = CW'(3*DIM-3);
    localparam logic [AW-1:0] c_LAST_ROW  = AW'(DIM-1);

    state_t          r_state;
    logic [CW-1:0]   r_step;
    logic [AW-1:0]   r_row;
    logic            w_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_row   <= '0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_row   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_COMPUTE;
                    r_step  <= '0;
                end
                S_COMPUTE: begin
                    if (!hold) begin
                        if (r_step == c_LAST_STEP) begin
                            r_state <= S_READ;
                            r_step  <= '0;
                            r_row   <= '0;
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (!hold) begin
                        if (r_row == c_LAST_ROW) begin
                            r_state <= S_DONE;
                            r_row   <= '0;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_step  <= '0;
                    r_row   <= '0;
                end
            endcase
        end
    end

    assign w_run    = (r_state == S_COMPUTE) && !hold;
    assign busy     = (r_state == S_CLEAR) || (r_state == S_COMPUTE) || (r_state == S_READ);
    assign done     = (r_state == S_DONE);
    assign mac_en   = w_run;
    assign mac_wren = (r_state == S_CLEAR);
    assign rd_valid = (r_state == S_READ) && !hold;
    assign rd_row   = r_row;
    assign step     = r_step;

    // Lane i is live while 0 <= step-i < DIM; the borrow bit of the widened
    // difference flags step < i.
    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        logic [CW:0] w_diff;
        logic        w_live;
        assign w_diff = {1'b0, r_step} - (CW+1)'(gi);
        assign w_live = w_run && !w_diff[CW] && (w_diff[CW-1:0] < CW'(DIM));
        assign feed_valid[gi]          = w_live;
        assign feed_addr[gi*AW +: AW]  = w_live ? w_diff[AW-1:0] : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_seq_ctrl
// Purpose  : Self-checking bench: progress-index controller model plus a
//            tpumac array model compared against a plain matrix product.
// Revision : 1.0  initial release
// ============================================================================
module tb_systolic_seq_ctrl;

    localparam int DIM   = 4;
    localparam int AW    = 2;
    localparam int CW    = 8;
    localparam int NCOMP = 3*DIM-2;
    localparam int OW    = 4 + DIM + DIM*AW + CW + 1 + AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              hold = 1'b0;
    logic              abort = 1'b0;
    logic              busy, done, mac_en, mac_wren, rd_valid;
    logic [DIM-1:0]    feed_valid;
    logic [DIM*AW-1:0] feed_addr;
    logic [CW-1:0]     step;
    logic [AW-1:0]     rd_row;

    systolic_seq_ctrl #(.DIM(DIM), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort),
        .busy(busy), .done(done), .mac_en(mac_en), .mac_wren(mac_wren),
        .feed_valid(feed_valid), .feed_addr(feed_addr), .step(step),
        .rd_valid(rd_valid), .rd_row(rd_row)
    );

    always #5 clk = ~clk;

    logic [OW-1:0]       dut_out;
    logic [OW-1:0]       exp_out;
    logic [DIM*16-1:0]   exp_row, got_row;
    assign dut_out = {busy, done, mac_en, mac_wren, feed_valid, feed_addr, step, rd_valid, rd_row};

    int n_cmp = 0;
    int n_err = 0;
    // pos: -1 idle, 0 clear, 1..NCOMP compute, then DIM read rows, then done
    int pos = -1;
    int done_seen, en_seen, rows_seen;

    logic signed [7:0] ma [DIM][DIM];
    logic signed [7:0] mb [DIM][DIM];
    logic [15:0]       ref_c [DIM][DIM];
    logic signed [7:0] ar [DIM][DIM];
    logic signed [7:0] br [DIM][DIM];
    logic [15:0]       cr [DIM][DIM];

    task automatic compute_ref();
        int acc;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                acc = 0;
                for (int k = 0; k < DIM; k++) acc += int'(ma[i][k]) * int'(mb[k][j]);
                ref_c[i][j] = acc[15:0];
            end
    endtask

    task automatic load_random(input bit zero_a);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                ma[r][c] = zero_a ? 8'sd0 : 8'($urandom);
                mb[r][c] = 8'($urandom);
            end
        compute_ref();
    endtask

    task automatic clear_counts();
        done_seen = 0; en_seen = 0; rows_seen = 0;
    endtask

    // Drives one cycle, prepares expectations, and advances both models.
    task automatic drive(input logic h, input logic a, input logic s);
        logic [DIM-1:0]    fv;
        logic [DIM*AW-1:0] fa;
        logic signed [7:0] na [DIM][DIM];
        logic signed [7:0] nb [DIM][DIM];
        logic signed [7:0] ain, bin;
        logic [AW-1:0]     erow;
        bit                in_comp, in_read;
        int                sx, p;
        @(negedge clk);
        hold = h; abort = a; start = s;
        #1;
        in_comp = (pos >= 1) && (pos <= NCOMP);
        in_read = (pos > NCOMP) && (pos <= NCOMP + DIM);
        sx = pos - 1;
        fv = '0; fa = '0;
        if (in_comp && !h)
            for (int i = 0; i < DIM; i++)
                if (sx >= i && sx - i < DIM) begin
                    fv[i] = 1'b1;
                    fa[i*AW +: AW] = AW'(sx - i);
                end
        erow = in_read ? AW'(pos - NCOMP - 1) : '0;
        exp_out = {(pos >= 0) && (pos <= NCOMP + DIM), pos == NCOMP + DIM + 1,
                   in_comp && !h, pos == 0, fv, fa,
                   in_comp ? CW'(sx) : CW'(0), in_read && !h, erow};
        for (int c = 0; c < DIM; c++) begin
            exp_row[c*16 +: 16] = ref_c[erow][c];
            got_row[c*16 +: 16] = cr[rd_row][c];
        end
        if (done)     done_seen++;
        if (mac_en)   en_seen++;
        if (rd_valid) rows_seen++;
        if (mac_wren) begin
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) cr[r][c] = '0;
        end else if (mac_en) begin
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    if (c == 0) ain = feed_valid[r] ? ma[r][feed_addr[r*AW +: AW]] : 8'sd0;
                    else        ain = ar[r][c-1];
                    if (r == 0) bin = feed_valid[c] ? mb[feed_addr[c*AW +: AW]][c] : 8'sd0;
                    else        bin = br[r-1][c];
                    na[r][c] = ain; nb[r][c] = bin;
                    p = int'(ain) * int'(bin);
                    cr[r][c] = cr[r][c] + p[15:0];
                end
            ar = na; br = nb;
        end
        if (a && pos >= 0)                pos = -1;
        else if (pos == -1)               pos = s ? 0 : -1;
        else if ((in_comp || in_read) && h) pos = pos;
        else if (pos == NCOMP + DIM + 1)  pos = -1;
        else                              pos = pos + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (dut_out !== exp_out) begin n_err++; $display("FAIL reset_outputs got=%h exp=%h", dut_out, exp_out); end
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_out !== exp_out) begin n_err++; $display("FAIL reset_idle got=%h exp=%h", dut_out, exp_out); end
    endtask

    task automatic test_basic();
        int bt[16] = '{-3, 7, 127, -128, 45, -1, 0, 2, -77, 12, 99, -50, 8, -8, 64, -100};
        int done_at = -1;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                ma[r][c] = 8'(r*DIM + c + 1);
                mb[r][c] = 8'(bt[r*DIM + c]);
            end
        compute_ref();
        clear_counts();
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 1'b0, k == 0);
            n_cmp++;
            if (dut_out !== exp_out) begin n_err++; $display("FAIL basic_cycle%0d got=%h exp=%h", k, dut_out, exp_out); end
            if (rd_valid) begin
                n_cmp++;
                if (got_row !== exp_row) begin n_err++; $display("FAIL basic_row%0d got=%h exp=%h", rd_row, got_row, exp_row); end
            end
            if (mac_en && step == 8'd3) begin
                n_cmp++;
                if ({feed_valid, feed_addr} !== {4'b1111, 2'd0, 2'd1, 2'd2, 2'd3}) begin
                    n_err++; $display("FAIL feed_step3 got=%b/%h exp=1111/1b", feed_valid, feed_addr);
                end
            end
            if (mac_en && step == 8'd5) begin
                n_cmp++;
                if ({feed_valid, feed_addr} !== {4'b1100, 2'd2, 2'd3, 2'd0, 2'd0}) begin
                    n_err++; $display("FAIL feed_step5 got=%b/%h exp=1100/b0", feed_valid, feed_addr);
                end
            end
            if (done) begin done_at = k; break; end
        end
        n_cmp++;
        if (done_at != 16) begin n_err++; $display("FAIL basic_length got=%0d exp=16", done_at); end
        n_cmp++;
        if (en_seen != 10 || rows_seen != 4 || done_seen != 1) begin
            n_err++; $display("FAIL basic_counts en=%0d rows=%0d done=%0d exp 10/4/1", en_seen, rows_seen, done_seen);
        end
    endtask

    task automatic test_hold();
        int done_at = -1;
        int h1 = 0, h2 = 0;
        logic h;
        load_random(1'b0);
        clear_counts();
        for (int k = 0; k < 60; k++) begin
            h = 1'b0;
            if (pos == 5 && h1 < 3) begin h = 1'b1; h1++; end
            if (pos == NCOMP + 2 && h2 < 2) begin h = 1'b1; h2++; end
            drive(h, 1'b0, k == 0);
            n_cmp++;
            if (dut_out !== exp_out) begin n_err++; $display("FAIL hold_cycle%0d got=%h exp=%h", k, dut_out, exp_out); end
            if (rd_valid) begin
                n_cmp++;
                if (got_row !== exp_row) begin n_err++; $display("FAIL hold_row%0d got=%h exp=%h", rd_row, got_row, exp_row); end
            end
            if (done) begin done_at = k; break; end
        end
        n_cmp++;
        if (done_at != 21 || en_seen != 10 || rows_seen != 4) begin
            n_err++; $display("FAIL hold_length got=%0d/%0d/%0d exp=21/10/4", done_at, en_seen, rows_seen);
        end
    endtask

    task automatic test_abort();
        int done_at = -1;
        load_random(1'b1);
        clear_counts();
        for (int k = 0; k < 14; k++) begin
            drive(1'b0, pos == 7, k == 0);
            n_cmp++;
            if (dut_out !== exp_out) begin n_err++; $display("FAIL abort_cycle%0d got=%h exp=%h", k, dut_out, exp_out); end
        end
        n_cmp++;
        if (done_seen != 0) begin n_err++; $display("FAIL abort_done got=%0d exp=0", done_seen); end
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) ma[r][c] = (r == c) ? 8'sd1 : 8'sd0;
        compute_ref();
        clear_counts();
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 1'b0, k == 0);
            n_cmp++;
            if (dut_out !== exp_out) begin n_err++; $display("FAIL rerun_cycle%0d got=%h exp=%h", k, dut_out, exp_out); end
            if (rd_valid) begin
                n_cmp++;
                if (got_row !== exp_row) begin n_err++; $display("FAIL rerun_row%0d got=%h exp=%h", rd_row, got_row, exp_row); end
            end
            if (done) begin done_at = k; break; end
        end
        n_cmp++;
        if (done_at != 16 || rows_seen != 4) begin n_err++; $display("FAIL rerun_length got=%0d/%0d exp=16/4", done_at, rows_seen); end
    endtask

    task automatic test_start_ignored();
        logic s;
        load_random(1'b0);
        clear_counts();
        for (int k = 0; k < 30; k++) begin
            s = (k == 0) || (pos >= 1 && pos <= NCOMP) || (pos == NCOMP + DIM + 1);
            drive(1'b0, 1'b0, s);
            n_cmp++;
            if (dut_out !== exp_out) begin n_err++; $display("FAIL ignore_cycle%0d got=%h exp=%h", k, dut_out, exp_out); end
        end
        n_cmp++;
        if (done_seen != 1) begin n_err++; $display("FAIL ignore_done got=%0d exp=1", done_seen); end
    endtask

    task automatic test_reset_mid_read();
        load_random(1'b0);
        for (int k = 0; k < 30; k++) begin
            drive(1'b0, 1'b0, k == 0);
            n_cmp++;
            if (dut_out !== exp_out) begin n_err++; $display("FAIL rstread_cycle%0d got=%h exp=%h", k, dut_out, exp_out); end
            if (pos == NCOMP + 2) break;
        end
        @(posedge clk);
        #2;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_row !== 2'd1) begin n_err++; $display("FAIL rstread_pre got=%b/%0d exp=1/1", rd_valid, rd_row); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_out !== '0) begin n_err++; $display("FAIL rstread_async got=%h exp=0", dut_out); end
        pos = -1;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_out !== exp_out) begin n_err++; $display("FAIL rstread_after got=%h exp=%h", dut_out, exp_out); end
    endtask

    task automatic test_back_to_back();
        int starts = 0;
        int done_at = -1;
        logic s;
        load_random(1'b0);
        clear_counts();
        for (int k = 0; k < 60; k++) begin
            s = (pos == -1) && (starts < 2);
            if (s) starts++;
            drive(1'b0, 1'b0, s);
            n_cmp++;
            if (dut_out !== exp_out) begin n_err++; $display("FAIL b2b_cycle%0d got=%h exp=%h", k, dut_out, exp_out); end
            if (rd_valid) begin
                n_cmp++;
                if (got_row !== exp_row) begin n_err++; $display("FAIL b2b_row%0d got=%h exp=%h", rd_row, got_row, exp_row); end
            end
            if (done && done_seen == 2) begin done_at = k; break; end
        end
        n_cmp++;
        if (done_at != 33 || rows_seen != 8) begin n_err++; $display("FAIL b2b_length got=%0d/%0d exp=33/8", done_at, rows_seen); end
    endtask

    task automatic test_random();
        for (int run = 0; run < 4; run++) begin
            load_random(1'b0);
            clear_counts();
            for (int k = 0; k < 200; k++) begin
                drive(($urandom_range(0, 3) == 0), 1'b0, k == 0);
                n_cmp++;
                if (dut_out !== exp_out) begin n_err++; $display("FAIL rand%0d_cycle%0d got=%h exp=%h", run, k, dut_out, exp_out); end
                if (rd_valid) begin
                    n_cmp++;
                    if (got_row !== exp_row) begin n_err++; $display("FAIL rand%0d_row%0d got=%h exp=%h", run, rd_row, got_row, exp_row); end
                end
                if (done) break;
            end
            n_cmp++;
            if (done_seen != 1 || rows_seen != 4 || en_seen != 10) begin
                n_err++; $display("FAIL rand%0d_counts done=%0d rows=%0d en=%0d exp 1/4/10", run, done_seen, rows_seen, en_seen);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_abort();
        test_start_ignored();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
